// File: rtl/alu_cmd_ctrl.sv
// Purpose: parses 0xCC/0xDD command frames, drives the ALU operand/function/enable regs, returns the 16-bit result as two TX bytes.
// Latency: ALU_EN one cycle after the FUN byte; result captured on OUT_VALID; first TX strobe one cycle later if TX is idle.
// Backpressure: TX_BUSY stalls SEND_LO/SEND_HI indefinitely; RX bytes arriving while a result is in flight are dropped with CMD_ERR.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int ALU_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_LOAD = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_EXEC = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_OPA, S_OPB, S_FUN, S_ALU_WAIT,
    S_SEND_LO, S_GAP_LO, S_SEND_HI, S_GAP_HI
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] alu_a, alu_a_nxt;
  logic [DATA_WIDTH-1:0] alu_b, alu_b_nxt;
  logic [3:0]            alu_fun, alu_fun_nxt;
  logic                  alu_en, alu_en_nxt;
  logic [DATA_WIDTH-1:0] tx_data, tx_data_nxt;
  logic                  tx_vld, tx_vld_nxt;
  logic                  cmd_err, cmd_err_nxt;
  logic [OUT_WIDTH-1:0]  result, result_nxt;
  logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                  busy_state;

  // State and every output are registered; reset returns to IDLE with all outputs clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= '0;
      alu_en  <= 1'b0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
      cmd_err <= 1'b0;
      result  <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      alu_a   <= alu_a_nxt;
      alu_b   <= alu_b_nxt;
      alu_fun <= alu_fun_nxt;
      alu_en  <= alu_en_nxt;
      tx_data <= tx_data_nxt;
      tx_vld  <= tx_vld_nxt;
      cmd_err <= cmd_err_nxt;
      result  <= result_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // A result is in flight from ALU_EN until the high byte has gone; RX bytes are refused meanwhile.
  assign busy_state = (state == S_ALU_WAIT) || (state == S_SEND_LO) || (state == S_GAP_LO) ||
                      (state == S_SEND_HI)  || (state == S_GAP_HI);

  // Next-state and next-output decode; strobes default low so they last exactly one cycle.
  always_comb begin
    state_nxt   = state;
    alu_a_nxt   = alu_a;
    alu_b_nxt   = alu_b;
    alu_fun_nxt = alu_fun;
    alu_en_nxt  = 1'b0;
    tx_data_nxt = tx_data;
    tx_vld_nxt  = 1'b0;
    cmd_err_nxt = 1'b0;
    result_nxt  = result;
    tmo_cnt_nxt = tmo_cnt;

    case (state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_LOAD)      state_nxt = S_OPA;
          else if (RX_P_DATA == CMD_EXEC) state_nxt = S_FUN;
          else                            cmd_err_nxt = 1'b1;
        end
      end
      S_OPA: begin
        if (RX_D_VLD) begin
          alu_a_nxt = RX_P_DATA;
          state_nxt = S_OPB;
        end
      end
      S_OPB: begin
        if (RX_D_VLD) begin
          alu_b_nxt = RX_P_DATA;
          state_nxt = S_FUN;
        end
      end
      S_FUN: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA[DATA_WIDTH-1:4] != '0) begin
            cmd_err_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            alu_fun_nxt = RX_P_DATA[3:0];
            alu_en_nxt  = 1'b1;
            tmo_cnt_nxt = '0;
            state_nxt   = S_ALU_WAIT;
          end
        end
      end
      S_ALU_WAIT: begin
        // OUT_VALID wins over a simultaneous timeout expiry.
        if (OUT_VALID) begin
          result_nxt = ALU_OUT;
          state_nxt  = S_SEND_LO;
        end else if (tmo_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
          cmd_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      S_SEND_LO: begin
        if (!TX_BUSY) begin
          tx_data_nxt = result[DATA_WIDTH-1:0];
          tx_vld_nxt  = 1'b1;
          state_nxt   = S_GAP_LO;
        end
      end
      // One dead cycle lets the transmitter raise TX_BUSY before we look at it again.
      S_GAP_LO: state_nxt = S_SEND_HI;
      S_SEND_HI: begin
        if (!TX_BUSY) begin
          tx_data_nxt = result[OUT_WIDTH-1:DATA_WIDTH];
          tx_vld_nxt  = 1'b1;
          state_nxt   = S_GAP_HI;
        end
      end
      S_GAP_HI: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Stray RX byte while a result is pending: drop it and flag, without disturbing the send.
    if (RX_D_VLD && busy_state) cmd_err_nxt = 1'b1;
  end

  assign ALU_A     = alu_a;
  assign ALU_B     = alu_b;
  assign ALU_FUN   = alu_fun;
  assign ALU_EN    = alu_en;
  assign TX_P_DATA = tx_data;
  assign TX_D_VLD  = tx_vld;
  assign CMD_ERR   = cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Purpose: directed bench for alu_cmd_ctrl with a registered ALU model and a TX byte monitor.
// Latency: ALU model answers one cycle after ALU_EN unless muted.
// Backpressure: TX_BUSY is driven directly by the stimulus to hold off transmission.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_D_VLD, CMD_ERR;

  logic        alu_mute = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          en_cnt = 0, err_cnt = 0, vld_cyc = 0;
  int          en_cyc = 0, err_cyc = 0;
  logic [7:0]  en_a = 8'h00, en_b = 8'h00;
  logic [3:0]  en_fun = 4'h0;
  logic [7:0]  tx_q[$];

  int en0, err0, vld0, txb;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(16), .ALU_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .TX_BUSY(TX_BUSY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Cycle counter, advanced on each active edge.
  always @(posedge CLK) cyc <= cyc + 1;

  // Registered ALU model: add (0), multiply (2), everything else 0.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT   <= 16'h0000;
    end else begin
      OUT_VALID <= ALU_EN && !alu_mute;
      case (ALU_FUN)
        4'h0:    ALU_OUT <= {8'h00, ALU_A} + {8'h00, ALU_B};
        4'h2:    ALU_OUT <= ALU_A * ALU_B;
        default: ALU_OUT <= 16'h0000;
      endcase
    end
  end

  // Mid-cycle monitor: counts strobes and records accepted TX bytes.
  always @(negedge CLK) begin
    if (ALU_EN) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
      en_a   <= ALU_A;
      en_b   <= ALU_B;
      en_fun <= ALU_FUN;
    end
    if (CMD_ERR) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (TX_D_VLD) vld_cyc <= vld_cyc + 1;
    if (TX_D_VLD && !TX_BUSY) tx_q.push_back(TX_P_DATA);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check(tag, 32'(tx_q.size()), 32'(n));
  endtask

  task automatic mark();
    en0  = en_cnt;
    err0 = err_cnt;
    vld0 = vld_cyc;
    txb  = tx_q.size();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed time limit expired");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #12;
    check("rst_alu_a",   32'(ALU_A), 32'h0);
    check("rst_alu_b",   32'(ALU_B), 32'h0);
    check("rst_alu_fun", 32'(ALU_FUN), 32'h0);
    check("rst_strobes", 32'({ALU_EN, TX_D_VLD, CMD_ERR}), 32'h0);
    check("rst_tx_data", 32'(TX_P_DATA), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    idle(2);

    // 5 + 3 = 0x0008.
    mark();
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    wait_tx("t1_tx_count", txb + 2, 40);
    idle(3);
    check("t1_en_cnt", 32'(en_cnt - en0), 32'd1);
    check("t1_en_a",   32'(en_a), 32'h05);
    check("t1_en_b",   32'(en_b), 32'h03);
    check("t1_en_fun", 32'(en_fun), 32'h0);
    check("t1_tx_lo",  32'(tx_q[txb]), 32'h08);
    check("t1_tx_hi",  32'(tx_q[txb+1]), 32'h00);
    check("t1_no_err", 32'(err_cnt - err0), 32'd0);

    // 0xFF * 0xFF = 0xFE01, then execute-only add on the stored operands = 0x01FE.
    mark();
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    wait_tx("t2_tx_count_mul", txb + 2, 40);
    idle(3);
    check("t2_mul_fun", 32'(en_fun), 32'h2);
    check("t2_mul_lo",  32'(tx_q[txb]), 32'h01);
    check("t2_mul_hi",  32'(tx_q[txb+1]), 32'hFE);
    send_byte(8'hDD); send_byte(8'h00);
    wait_tx("t2_tx_count_add", txb + 4, 40);
    idle(3);
    check("t2_en_cnt",  32'(en_cnt - en0), 32'd2);
    check("t2_dd_a",    32'(en_a), 32'hFF);
    check("t2_dd_b",    32'(en_b), 32'hFF);
    check("t2_dd_fun",  32'(en_fun), 32'h0);
    check("t2_add_lo",  32'(tx_q[txb+2]), 32'hFE);
    check("t2_add_hi",  32'(tx_q[txb+3]), 32'h01);
    check("t2_no_err",  32'(err_cnt - err0), 32'd0);

    // Bad command byte in IDLE.
    mark();
    send_byte(8'h55);
    idle(3);
    check("t3_bad_cmd_err", 32'(err_cnt - err0), 32'd1);
    check("t3_bad_cmd_en",  32'(en_cnt - en0), 32'd0);
    // Set FUN=2 so an unchanged ALU_FUN is observable, then a bad function byte.
    send_byte(8'hDD); send_byte(8'h02);
    wait_tx("t3_tx_count", txb + 2, 40);
    idle(3);
    check("t3_dd_mul_lo", 32'(tx_q[txb]), 32'h01);
    mark();
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1F);
    idle(4);
    check("t3_bad_fun_err", 32'(err_cnt - err0), 32'd1);
    check("t3_bad_fun_en",  32'(en_cnt - en0), 32'd0);
    check("t3_fun_kept",    32'(ALU_FUN), 32'h2);

    // ALU never answers: timeout four cycles after ALU_EN, then recovery.
    mark();
    alu_mute = 1'b1;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h00);
    idle(8);
    check("t4_tmo_en",    32'(en_cnt - en0), 32'd1);
    check("t4_tmo_err",   32'(err_cnt - err0), 32'd1);
    check("t4_tmo_delay", 32'(err_cyc - en_cyc), 32'd4);
    check("t4_tmo_no_tx", 32'(tx_q.size() - txb), 32'd0);
    alu_mute = 1'b0;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h00);
    wait_tx("t4_tx_count", txb + 2, 40);
    idle(3);
    check("t4_rec_lo",  32'(tx_q[txb]), 32'h09);
    check("t4_rec_hi",  32'(tx_q[txb+1]), 32'h00);
    check("t4_rec_err", 32'(err_cnt - err0), 32'd1);

    // TX_BUSY held for 20 cycles at SEND_LO with a stray RX byte in the middle.
    mark();
    TX_BUSY = 1'b1;
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    idle(5);
    send_byte(8'h77);
    idle(14);
    check("t5_busy_no_vld", 32'(vld_cyc - vld0), 32'd0);
    check("t5_stray_err",   32'(err_cnt - err0), 32'd1);
    TX_BUSY = 1'b0;
    wait_tx("t5_tx_count", txb + 2, 40);
    idle(3);
    check("t5_vld_strobes", 32'(vld_cyc - vld0), 32'd2);
    check("t5_tx_lo",       32'(tx_q[txb]), 32'h30);
    check("t5_tx_hi",       32'(tx_q[txb+1]), 32'h00);

    // Asynchronous reset mid-frame clears operands; execute-only then runs on zeros.
    send_byte(8'hCC); send_byte(8'h11);
    RST = 1'b0;
    #2;
    check("t6_rst_alu_a",   32'(ALU_A), 32'h0);
    check("t6_rst_alu_b",   32'(ALU_B), 32'h0);
    check("t6_rst_strobes", 32'({ALU_EN, TX_D_VLD, CMD_ERR}), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    idle(1);
    mark();
    send_byte(8'hDD); send_byte(8'h00);
    wait_tx("t6_tx_count", txb + 2, 40);
    idle(3);
    check("t6_en_cnt", 32'(en_cnt - en0), 32'd1);
    check("t6_en_a",   32'(en_a), 32'h00);
    check("t6_en_b",   32'(en_b), 32'h00);
    check("t6_tx_lo",  32'(tx_q[txb]), 32'h00);
    check("t6_tx_hi",  32'(tx_q[txb+1]), 32'h00);
    check("t6_no_err", 32'(err_cnt - err0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
